// File: rtl/mac_accum_block_if.sv
// mac_accum_block_if
//   Bundles the product-input and result-output channels of the MAC
//   accumulator stage.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. The producer holds valid and its payload until that edge, and
//   ready may depend combinationally on the consumer's own state.
//     input channel : in_valid / in_ready, payload in_last + C (+ en, cfg)
//     output channel: out_valid / out_ready, payload acc_out, cnt_out, ovf_out
//
//   Modports:
//     master - upstream/downstream environment side
//     slave  - the accumulator block
interface mac_accum_block_if #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 48,
    parameter int MAC_CNT_WIDTH  = 16
) ();
    logic                      en;
    logic [MAC_CONF_WIDTH-1:0] cfg;
    logic                      in_valid;
    logic                      in_last;
    logic [MAC_INT_WIDTH-1:0]  C;
    logic                      in_ready;
    logic [MAC_ACC_WIDTH-1:0]  acc_out;
    logic [MAC_CNT_WIDTH-1:0]  cnt_out;
    logic                      ovf_out;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output en, cfg, in_valid, in_last, C, out_ready,
        input  in_ready, acc_out, cnt_out, ovf_out, out_valid
    );

    modport slave (
        input  en, cfg, in_valid, in_last, C, out_ready,
        output in_ready, acc_out, cnt_out, ovf_out, out_valid
    );
endinterface

// File: rtl/mac_accum_block.sv
// mac_accum_block
//   Accumulates the unsigned product beats of the MAC multiply stage. Each
//   beat is masked to the width produced by the active Single/Dual/Quad config,
//   zero-extended and added into a wide accumulator. A last beat moves the
//   total, term count and sticky overflow flag into a one-entry result buffer
//   that is drained through out_valid/out_ready.
//
//   Optional feature: define MAC_ACC_SAT_EN to clamp the accumulator to
//   all-ones on carry-out (default build wraps modulo 2^MAC_ACC_WIDTH).
//
//   Ports:
//     clk       - clock, rising edge
//     rst       - asynchronous active-low reset
//     bus       - mac_accum_block_if.slave: en, cfg, in_valid, in_last, C,
//                 in_ready, acc_out, cnt_out, ovf_out, out_valid, out_ready
//     dbg_state - current FSM state (0 = IDLE, 1 = ACCUM)
module mac_accum_block #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 48,
    parameter int MAC_CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    mac_accum_block_if.slave   bus,
    output logic [0:0]         dbg_state
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Single mode yields 2*MIN product bits, dual 3*MIN, quad the full word.
    localparam int SGL_W  = 2 * MAC_MIN_WIDTH;
    localparam int DUAL_W = 3 * MAC_MIN_WIDTH;
    localparam logic [MAC_INT_WIDTH-1:0] MASK_SGL =
        {{(MAC_INT_WIDTH - SGL_W){1'b0}}, {SGL_W{1'b1}}};
    localparam logic [MAC_INT_WIDTH-1:0] MASK_DUAL =
        {{(MAC_INT_WIDTH - DUAL_W){1'b0}}, {DUAL_W{1'b1}}};

    logic [0:0]               state_q, state_d;
    logic [1:0]               cfg_q, cfg_d;
    logic [MAC_ACC_WIDTH-1:0] acc_q, acc_d;
    logic [MAC_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [MAC_ACC_WIDTH-1:0] res_acc_q, res_acc_d;
    logic [MAC_CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
    logic                     res_ovf_q, res_ovf_d;
    logic                     out_valid_q, out_valid_d;

    logic [1:0]               cfg_eff;
    logic [MAC_INT_WIDTH-1:0] c_masked;
    logic [MAC_ACC_WIDTH-1:0] term;
    logic [MAC_ACC_WIDTH-1:0] acc_base;
    logic [MAC_ACC_WIDTH:0]   sum_full;
    logic                     carry;
    logic [MAC_ACC_WIDTH-1:0] acc_next;
    logic [MAC_CNT_WIDTH-1:0] cnt_next;
    logic                     ovf_next;
    logic                     in_ready;
    logic                     accept;

    // Only cfg[1:0] selects the mode; upper config bits are don't-care.
    wire unused_cfg = ^bus.cfg;

    always_comb begin
        // The first beat of a sequence uses the live cfg; later beats use the
        // value captured with that first beat.
        cfg_eff = (state_q == ST_IDLE) ? bus.cfg[1:0] : cfg_q;
        case (cfg_eff)
            2'b00:   c_masked = bus.C & MASK_SGL;
            2'b01:   c_masked = bus.C & MASK_DUAL;
            default: c_masked = bus.C;
        endcase
        term = MAC_ACC_WIDTH'(c_masked);

        // In IDLE the sum starts from zero, so the first term never carries.
        acc_base = (state_q == ST_IDLE) ? '0 : acc_q;
        sum_full = {1'b0, acc_base} + {1'b0, term};
        carry    = sum_full[MAC_ACC_WIDTH];
`ifdef MAC_ACC_SAT_EN
        // Once clamped, every further add also carries (or adds 0), so the
        // accumulator stays at all-ones for the rest of the sequence.
        acc_next = carry ? '1 : sum_full[MAC_ACC_WIDTH-1:0];
`else
        acc_next = sum_full[MAC_ACC_WIDTH-1:0];
`endif
        ovf_next = ((state_q == ST_IDLE) ? 1'b0 : ovf_q) | carry;
        if (state_q == ST_IDLE)
            cnt_next = MAC_CNT_WIDTH'(1);
        else if (&cnt_q)
            cnt_next = cnt_q;
        else
            cnt_next = cnt_q + MAC_CNT_WIDTH'(1);

        // The buffer is free when empty or being drained this cycle.
        in_ready = bus.en & (~out_valid_q | bus.out_ready);
        accept   = bus.in_valid & in_ready;

        state_d     = state_q;
        cfg_d       = cfg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_acc_d   = res_acc_q;
        res_cnt_d   = res_cnt_q;
        res_ovf_d   = res_ovf_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;

        if (accept) begin
            if (state_q == ST_IDLE)
                cfg_d = bus.cfg[1:0];
            if (bus.in_last) begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                res_acc_d   = acc_next;
                res_cnt_d   = cnt_next;
                res_ovf_d   = ovf_next;
                out_valid_d = 1'b1;
            end else begin
                state_d = ST_ACCUM;
                acc_d   = acc_next;
                cnt_d   = cnt_next;
                ovf_d   = ovf_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= 2'b00;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_acc_q   <= '0;
            res_cnt_q   <= '0;
            res_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_acc_q   <= res_acc_d;
            res_cnt_q   <= res_cnt_d;
            res_ovf_q   <= res_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.acc_out   = res_acc_q;
    assign bus.cnt_out   = res_cnt_q;
    assign bus.ovf_out   = res_ovf_q;
    assign bus.out_valid = out_valid_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mac_accum_block.sv
module tb_mac_accum_block;
    logic       clk;
    logic       rst;
    logic [0:0] dbg_state;
    logic [0:0] dbg_state40;
    int checks;
    int errors;

    mac_accum_block_if #(.MAC_ACC_WIDTH(48), .MAC_CNT_WIDTH(16)) bus ();
    mac_accum_block_if #(.MAC_ACC_WIDTH(40), .MAC_CNT_WIDTH(2))  bus40 ();

    mac_accum_block #(.MAC_ACC_WIDTH(48), .MAC_CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );
    // Narrow accumulator for overflow checks, 2-bit counter for saturation.
    mac_accum_block #(.MAC_ACC_WIDTH(40), .MAC_CNT_WIDTH(2)) u_dut40 (
        .clk(clk), .rst(rst), .bus(bus40), .dbg_state(dbg_state40)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic last, input logic [2:0] cfg, input logic [39:0] c);
        bus.in_valid = v;
        bus.in_last  = last;
        bus.cfg      = cfg;
        bus.C        = c;
    endtask

    task automatic drive40(input logic v, input logic last, input logic [2:0] cfg, input logic [39:0] c);
        bus40.in_valid = v;
        bus40.in_last  = last;
        bus40.cfg      = cfg;
        bus40.C        = c;
    endtask

    initial begin
        logic [39:0] exp_ovf_acc;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.en = 1'b1;     bus.out_ready = 1'b0;
        bus40.en = 1'b1;   bus40.out_ready = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 40'h0);
        drive40(1'b0, 1'b0, 3'b000, 40'h0);
        #12;
        // reset state
        check("rst_acc",       64'(bus.acc_out), 64'h0);
        check("rst_cnt",       64'(bus.cnt_out), 64'h0);
        check("rst_ovf",       64'(bus.ovf_out), 64'h0);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_state",     64'(dbg_state), 64'h0);
        check("rst_in_ready",  64'(bus.in_ready), 64'h1);
        check("rst40_cnt",     64'(bus40.cnt_out), 64'h0);
        tick();
        rst = 1'b1;

        // single-beat sequence, single-mode mask
        drive(1'b1, 1'b1, 3'b000, 40'hFF_FFFF_1234);
        tick();
        check("single_acc",   64'(bus.acc_out), 64'h1234);
        check("single_cnt",   64'(bus.cnt_out), 64'h1);
        check("single_ovf",   64'(bus.ovf_out), 64'h0);
        check("single_valid", 64'(bus.out_valid), 64'h1);
        drive(1'b0, 1'b0, 3'b000, 40'h0);
        bus.out_ready = 1'b1;
        tick();
        check("single_drain", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 1'b0;

        // quad sequence, cfg switched mid-sequence is ignored
        drive(1'b1, 1'b0, 3'b010, 40'h10_0000_0000);
        tick();
        check("quad_state_accum", 64'(dbg_state), 64'h1);
        check("quad_no_valid",    64'(bus.out_valid), 64'h0);
        drive(1'b1, 1'b0, 3'b000, 40'h1);
        tick();
        drive(1'b1, 1'b1, 3'b000, 40'h2);
        tick();
        check("quad_acc",   64'(bus.acc_out), 64'h10_0000_0003);
        check("quad_cnt",   64'(bus.cnt_out), 64'h3);
        check("quad_valid", 64'(bus.out_valid), 64'h1);
        check("quad_idle",  64'(dbg_state), 64'h0);

        // backpressure: full buffer blocks input
        drive(1'b1, 1'b0, 3'b001, 40'hAB_CDEF_1234);
        #1;
        check("bp_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        tick();
        check("bp_hold_acc",   64'(bus.acc_out), 64'h10_0000_0003);
        check("bp_hold_valid", 64'(bus.out_valid), 64'h1);
        check("bp_hold_state", 64'(dbg_state), 64'h0);
        // drain and a new last beat in the same cycle; dual mask
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 3'b001, 40'hAB_CDEF_1234);
        #1;
        check("bp_in_ready_drain", 64'(bus.in_ready), 64'h1);
        tick();
        check("bp_reload_valid", 64'(bus.out_valid), 64'h1);
        check("bp_reload_acc",   64'(bus.acc_out), 64'hEF_1234);
        check("bp_reload_cnt",   64'(bus.cnt_out), 64'h1);
        drive(1'b0, 1'b0, 3'b000, 40'h0);
        tick();
        check("bp_drain", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 1'b0;

        // overflow on the 40-bit accumulator; cfg 3'b111 acts as quad
`ifdef MAC_ACC_SAT_EN
        exp_ovf_acc = 40'hFF_FFFF_FFFF;
`else
        exp_ovf_acc = 40'h1;
`endif
        drive40(1'b1, 1'b0, 3'b111, 40'hFF_FFFF_FFFF);
        tick();
        check("ovf_state_accum", 64'(dbg_state40), 64'h1);
        drive40(1'b1, 1'b1, 3'b000, 40'h2);
        tick();
        check("ovf_acc",   64'(bus40.acc_out), 64'(exp_ovf_acc));
        check("ovf_flag",  64'(bus40.ovf_out), 64'h1);
        check("ovf_cnt",   64'(bus40.cnt_out), 64'h2);
        check("ovf_valid", 64'(bus40.out_valid), 64'h1);
        drive40(1'b0, 1'b0, 3'b000, 40'h0);
        bus40.out_ready = 1'b1;
        tick();
        bus40.out_ready = 1'b0;

        // counter saturation: 5 terms into a 2-bit counter
        drive40(1'b1, 1'b0, 3'b010, 40'h1);
        for (int i = 0; i < 4; i++) tick();
        drive40(1'b1, 1'b1, 3'b010, 40'h1);
        tick();
        check("sat_cnt", 64'(bus40.cnt_out), 64'h3);
        check("sat_acc", 64'(bus40.acc_out), 64'h5);
        check("sat_ovf_cleared", 64'(bus40.ovf_out), 64'h0);
        drive40(1'b0, 1'b0, 3'b000, 40'h0);

        // async reset in the middle of an accumulation
        drive(1'b1, 1'b1, 3'b000, 40'h3);
        tick();
        check("pre_rst_acc", 64'(bus.acc_out), 64'h3);
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 3'b000, 40'h4);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 40'h6);
        tick();
        check("pre_rst_state", 64'(dbg_state), 64'h1);
        drive(1'b0, 1'b0, 3'b000, 40'h0);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_acc",   64'(bus.acc_out), 64'h0);
        check("async_rst_cnt",   64'(bus.cnt_out), 64'h0);
        check("async_rst_state", 64'(dbg_state), 64'h0);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 3'b000, 40'h5);
        tick();
        check("post_rst_acc",   64'(bus.acc_out), 64'h5);
        check("post_rst_cnt",   64'(bus.cnt_out), 64'h1);
        check("post_rst_valid", 64'(bus.out_valid), 64'h1);

        // enable gating with a pending result
        bus.en = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 40'h7);
        #1;
        check("en_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        tick();
        check("en_hold_state", 64'(dbg_state), 64'h0);
        check("en_hold_valid", 64'(bus.out_valid), 64'h1);
        bus.out_ready = 1'b1;
        #1;
        check("en_in_ready_drain", 64'(bus.in_ready), 64'h0);
        tick();
        check("en_drain", 64'(bus.out_valid), 64'h0);
        check("en_no_accept", 64'(dbg_state), 64'h0);
        bus.out_ready = 1'b0;
        bus.en = 1'b1;
        drive(1'b1, 1'b1, 3'b000, 40'h7);
        tick();
        check("en_resume_acc", 64'(bus.acc_out), 64'h7);
        check("en_resume_cnt", 64'(bus.cnt_out), 64'h1);
        drive(1'b0, 1'b0, 3'b000, 40'h0);
        tick();

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_accum_block.md
# mac_accum_block

Accumulator stage directly downstream of the MAC multiply block. Consumes the 40-bit unsigned product word per beat, masks it to the width the active Single/Dual/Quad config produces, and sums beats into a wide accumulator. A sequence ends on a `last` beat: the total, term count and overflow flag are registered into a one-entry output buffer. The buffer is handed downstream via valid/ready.

## Interface

Parameters:
- `MAC_CONF_WIDTH`, default 3: config bus width.
- `MAC_MIN_WIDTH`, default 8: base operand width.
- `MAC_INT_WIDTH`, default 5*MAC_MIN_WIDTH: product input width.
- `MAC_ACC_WIDTH`, default 48: accumulator/result width; must be ≥ MAC_INT_WIDTH.
- `MAC_CNT_WIDTH`, default 16: term-counter width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: **asynchronous, active-low** reset.
- `en` in 1: stage enable; gates input acceptance only.
- `cfg` in MAC_CONF_WIDTH: 2'b00 single, 2'b01 dual, 2'b10 quad, 2'b11 treated as quad; cfg[2] ignored.
- `in_valid` in 1: product beat valid.
- `in_last` in 1: beat closes the sequence.
- `C` in MAC_INT_WIDTH: unsigned product from multiply stage.
- `in_ready` out 1: beat accepted when in_valid & in_ready.
- `acc_out` out MAC_ACC_WIDTH: sequence result.
- `cnt_out` out MAC_CNT_WIDTH: number of terms in result.
- `ovf_out` out 1: sticky overflow for the sequence.
- `out_valid` out 1: result buffer full.
- `out_ready` in 1: downstream accepts when out_valid & out_ready.

## Operation

Masking:
- single: C[15:0]
- dual: C[23:0]
- quad/11: C[39:0]
- Zero-extend the masked value to MAC_ACC_WIDTH.

Config latching:
- cfg is latched on the first accepted beat of a sequence (IDLE state) into `cfg_q`.
- All later beats of the same sequence use `cfg_q`; cfg changes mid-sequence are ignored.

FSM states:
- **IDLE**: acc=0, cnt=0, ovf=0.
- **ACCUM**: partial sum held.

Transitions:
- IDLE, accept, !last → ACCUM: acc=term, cnt=1.
- IDLE, accept, last → IDLE: result=term, count 1, ovf 0, loaded into the buffer.
- ACCUM, accept, !last → ACCUM: acc+=term, cnt+=1, ovf|=carry.
- ACCUM, accept, last → IDLE: buffer ← (acc+term, cnt+1, ovf|carry); acc, cnt, ovf cleared.

Handshake:
- `in_ready = en & (!out_valid | out_ready)`.
- A last beat is never accepted while the buffer cannot be freed. Non-last beats follow the same rule.
- `out_valid` sets on an accepted last beat.
- `out_valid` clears on out_ready when no new last beat arrives the same cycle.
- Simultaneous drain and new last: buffer reloads and out_valid stays 1.

Counter and enable:
- cnt saturates at all-ones and does not wrap.
- en=0: in_ready=0 and the accumulator freezes. Output drain still works.

## Timing

- Reset (async assert, sync-safe deassert) values: acc_out=0, cnt_out=0, ovf_out=0, out_valid=0, FSM=IDLE, cfg_q=0. in_ready follows en after reset.
- Throughput: 1 beat/cycle.
- Latency: results appear on acc_out/cnt_out/ovf_out with out_valid=1 the cycle after the last beat is accepted.
- Outputs stay stable while out_valid & !out_ready.
- Reset mid-sequence discards partial sum and buffer; no output produced.
- in_valid=0: no state change regardless of in_last.

## Configuration

- `MAC_ACC_SAT_EN` defined: on carry out of MAC_ACC_WIDTH, acc clamps to all-ones and holds for the rest of the sequence. ovf is set.
- `MAC_ACC_SAT_EN` undefined: sum wraps modulo 2^MAC_ACC_WIDTH. ovf is still set sticky on any carry.

## Test plan

- **Single-beat sequence**: cfg=00, C=40'hFF_FFFF_1234, in_last=1 → next cycle acc_out=48'h1234, cnt_out=1, ovf_out=0, out_valid=1.
- **Quad sequence with mid-sequence cfg change**: cfg=10, beats 40'h10_0000_0000, 40'h1, 40'h2 (last); cfg switched to 00 after beat 1 → acc_out=48'h10_0000_0003, cnt_out=3.
- **Backpressure**: result held with out_ready=0 → in_ready=0, next beats stall. out_ready=1 together with a new last beat → out_valid stays 1 and the new result is loaded.
- **Overflow, MAC_ACC_WIDTH=40, quad**: beats 40'hFF_FFFF_FFFF and 40'h2 (last) → wrap build acc_out=1, ovf_out=1; sat build acc_out=40'hFF_FFFF_FFFF, ovf_out=1.
- **Async reset mid-ACCUM**: after 2 beats, pulse rst low between edges → outputs 0 immediately. New single beat 5 (last) → acc_out=5, cnt_out=1.
- **en gating**: en=0 with in_valid=1 for 3 cycles → in_ready=0 and acc unchanged. Pending out_valid still drains on out_ready.
